// File: rtl/regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module  : regfile_writeback
// Brief   : Two-source (ALU / load) write-back collector with per-source FIFOs,
//           round-robin arbitration and a pending-write hazard mask.
// Revision: 1.0  initial release
// ============================================================================
module regfile_writeback #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              wb_write,
  output logic [ADDR_W-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic [15:0]       busy_mask
);

  localparam int             c_PW   = $clog2(DEPTH);
  localparam logic [c_PW:0]  c_ONE  = (c_PW+1)'(1);
  localparam logic [c_PW:0]  c_FULL = (c_PW+1)'(DEPTH);

  // Source index 0 is the ALU, 1 is the load unit.
  logic [1:0]             w_in_valid;
  logic [1:0][ADDR_W-1:0] w_in_rd;
  logic [1:0][DATA_W-1:0] w_in_data;
  logic [1:0]             w_ready;
  logic [1:0]             w_push;
  logic [1:0]             w_full;
  logic [1:0]             w_nempty;
  logic [1:0]             w_grant;
  logic [1:0][ADDR_W-1:0] w_head_rd;
  logic [1:0][DATA_W-1:0] w_head_data;
  logic [1:0][15:0]       w_src_mask;
  logic                   r_last_mem;

  assign w_in_valid = {mem_valid, alu_valid};
  assign w_in_rd    = {mem_rd, alu_rd};
  assign w_in_data  = {mem_data, alu_data};
  assign w_ready    = {rst && !w_full[1], rst && !w_full[0]};
  assign w_push     = w_in_valid & w_ready;
  assign alu_ready  = w_ready[0];
  assign mem_ready  = w_ready[1];

  for (genvar s = 0; s < 2; s++) begin : g_src
    logic [ADDR_W-1:0] r_rd   [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [c_PW-1:0]   r_wp;
    logic [c_PW-1:0]   r_rp;
    logic [c_PW:0]     r_cnt;
    logic [c_PW-1:0]   w_off;
    logic [15:0]       w_m;

    always_ff @(posedge clk) begin
      if (w_push[s]) begin
        r_rd[r_wp]   <= w_in_rd[s];
        r_data[r_wp] <= w_in_data[s];
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_wp  <= '0;
        r_rp  <= '0;
        r_cnt <= '0;
      end else begin
        if (w_push[s])  r_wp <= r_wp + 1'b1;
        if (w_grant[s]) r_rp <= r_rp + 1'b1;
        if (w_push[s] && !w_grant[s])      r_cnt <= r_cnt + c_ONE;
        else if (!w_push[s] && w_grant[s]) r_cnt <= r_cnt - c_ONE;
      end
    end

    // An entry is occupied when its distance from the head is below the count.
    always_comb begin
      w_m   = '0;
      w_off = '0;
      for (int i = 0; i < DEPTH; i++) begin
        w_off = c_PW'(i) - r_rp;
        if ({1'b0, w_off} < r_cnt) w_m = w_m | (16'd1 << r_rd[i]);
      end
    end

    assign w_full[s]      = (r_cnt == c_FULL);
    assign w_nempty[s]    = (r_cnt != '0);
    assign w_head_rd[s]   = r_rd[r_rp];
    assign w_head_data[s] = r_data[r_rp];
    assign w_src_mask[s]  = w_m;
  end

  assign w_grant[0] = w_nempty[0] && (!w_nempty[1] || r_last_mem);
  assign w_grant[1] = w_nempty[1] && !w_grant[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_write   <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      r_last_mem <= 1'b1;
    end else if (|w_grant) begin
      wb_write   <= 1'b1;
      wb_rd      <= w_grant[0] ? w_head_rd[0]   : w_head_rd[1];
      wb_data    <= w_grant[0] ? w_head_data[0] : w_head_data[1];
      r_last_mem <= w_grant[1];
    end else begin
      wb_write   <= 1'b0;
    end
  end

  assign busy_mask = w_src_mask[0] | w_src_mask[1] |
                     (wb_write ? (16'd1 << wb_rd) : 16'd0);

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module  : tb_regfile_writeback
// Brief   : Directed bench with a queue-based reference model for
//           regfile_writeback.
// Revision: 1.0  initial release
// ============================================================================
module tb_regfile_writeback;
  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid, mem_valid;
  logic          alu_ready, mem_ready;
  logic [AW-1:0] alu_rd, mem_rd, wb_rd;
  logic [DW-1:0] alu_data, mem_data, wb_data;
  logic          wb_write;
  logic [15:0]   busy_mask;

  regfile_writeback #(.DEPTH(DEPTH), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_write(wb_write), .wb_rd(wb_rd), .wb_data(wb_data), .busy_mask(busy_mask)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: one queue per source, entries are {rd, data}.
  logic [35:0] aq[$];
  logic [35:0] mq[$];
  bit          m_last_mem = 1'b1;
  logic        m_wr   = 1'b0;
  logic [3:0]  m_rd   = '0;
  logic [31:0] m_data = '0;
  bit          pa, pm;
  logic [35:0] e;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      aq.delete(); mq.delete();
      m_last_mem = 1'b1; m_wr = 1'b0; m_rd = '0; m_data = '0;
    end else begin
      pa = alu_valid && (aq.size() < DEPTH);
      pm = mem_valid && (mq.size() < DEPTH);
      if (aq.size() > 0 && (mq.size() == 0 || m_last_mem)) begin
        e = aq.pop_front(); m_wr = 1'b1; {m_rd, m_data} = e; m_last_mem = 1'b0;
      end else if (mq.size() > 0) begin
        e = mq.pop_front(); m_wr = 1'b1; {m_rd, m_data} = e; m_last_mem = 1'b1;
      end else begin
        m_wr = 1'b0;
      end
      if (pa) aq.push_back({alu_rd, alu_data});
      if (pm) mq.push_back({mem_rd, mem_data});
    end
  end

  function automatic logic [15:0] model_busy();
    logic [15:0] b = '0;
    foreach (aq[i]) b |= 16'd1 << aq[i][35:32];
    foreach (mq[i]) b |= 16'd1 << mq[i][35:32];
    if (m_wr) b |= 16'd1 << m_rd;
    return b;
  endfunction

  // Per-cycle comparison and a log of observed writes.
  logic [35:0] wlog[$];
  int          wcyc[$];
  int          cyc_n = 0;

  always @(negedge clk) begin
    cyc_n++;
    chk("wb_write",  wb_write,  m_wr);
    chk("wb_rd",     wb_rd,     m_rd);
    chk("wb_data",   wb_data,   m_data);
    chk("busy_mask", busy_mask, model_busy());
    chk("alu_ready", alu_ready, rst && (aq.size() < DEPTH));
    chk("mem_ready", mem_ready, rst && (mq.size() < DEPTH));
    if (wb_write === 1'b1) begin
      wlog.push_back({wb_rd, wb_data});
      wcyc.push_back(cyc_n);
    end
  end

  task automatic cyc();
    @(negedge clk); #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((busy_mask !== 16'd0 || wb_write !== 1'b0) && n < 50) begin
      cyc(); n++;
    end
    chk({name, "_drain_timeout"}, (n < 50), 1);
  endtask

  logic [35:0] exp3 [8] = '{36'h1_00000010, 36'h2_00000020, 36'h1_00000011, 36'h2_00000021,
                            36'h1_00000012, 36'h2_00000022, 36'h1_00000013, 36'h2_00000023};
  logic [31:0] memv[$];

  initial begin
    int sent, guard;
    bit acc_m, acc_a, seen_drop;

    // 1. reset with random inputs
    rst = 1'b0;
    alu_valid = 0; mem_valid = 0; alu_rd = 0; mem_rd = 0; alu_data = 0; mem_data = 0;
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'($urandom); mem_valid = 1'($urandom);
      alu_rd = 4'($urandom); mem_rd = 4'($urandom);
      alu_data = $urandom; mem_data = $urandom;
      cyc();
      chk("rst_wb_write", wb_write, 0);
      chk("rst_wb_rd", wb_rd, 0);
      chk("rst_wb_data", wb_data, 0);
      chk("rst_busy", busy_mask, 0);
      chk("rst_ready", {alu_ready, mem_ready}, 0);
    end
    alu_valid = 0; mem_valid = 0; rst = 1'b1;
    cyc();
    chk("rel_ready", {alu_ready, mem_ready}, 2'b11);

    // 2. single ALU write
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    cyc();
    alu_valid = 0;
    chk("t2_busy5_queued", busy_mask[5], 1);
    chk("t2_no_write_yet", wb_write, 0);
    cyc();
    chk("t2_write", wb_write, 1);
    chk("t2_rd", wb_rd, 5);
    chk("t2_data", wb_data, 32'hDEADBEEF);
    chk("t2_busy5_wb", busy_mask[5], 1);
    cyc();
    chk("t2_write_fell", wb_write, 0);
    chk("t2_busy5_clear", busy_mask[5], 0);

    // 5. mem-only burst (leaves last grant at MEM)
    wlog.delete(); wcyc.delete();
    mem_valid = 1; mem_rd = 3;
    for (int d = 1; d <= 3; d++) begin
      mem_data = d; cyc();
    end
    mem_valid = 0;
    cyc();
    chk("t5_busy3_last", busy_mask[3], 1);
    cyc();
    chk("t5_write_off", wb_write, 0);
    chk("t5_busy3_clear", busy_mask[3], 0);
    chk("t5_count", wlog.size(), 3);
    if (wlog.size() == 3) begin
      for (int i = 0; i < 3; i++) chk("t5_val", wlog[i], {4'd3, 32'(i + 1)});
      chk("t5_consec", (wcyc[1] == wcyc[0] + 1) && (wcyc[2] == wcyc[1] + 1), 1);
    end

    // 3. contention
    wlog.delete();
    alu_valid = 1; mem_valid = 1; alu_rd = 1; mem_rd = 2;
    for (int i = 0; i < 4; i++) begin
      alu_data = 32'h10 + i; mem_data = 32'h20 + i; cyc();
    end
    alu_valid = 0; mem_valid = 0;
    drain("t3");
    chk("t3_count", wlog.size(), 8);
    if (wlog.size() == 8)
      for (int i = 0; i < 8; i++) chk("t3_seq", wlog[i], exp3[i]);

    // 4. backpressure on mem while ALU pushes every cycle
    wlog.delete();
    alu_rd = 7; mem_rd = 9; alu_data = 32'h100; mem_data = 1;
    alu_valid = 1; mem_valid = 1;
    sent = 0; guard = 0; seen_drop = 0;
    while (sent < 8 && guard < 100) begin
      acc_m = mem_ready; acc_a = alu_ready;
      if (!mem_ready && !seen_drop) begin
        seen_drop = 1;
        chk("t4_full_at_drop", mq.size(), 4);
      end
      cyc(); guard++;
      if (acc_m) begin sent++; mem_data = sent + 1; end
      if (acc_a) alu_data = alu_data + 1;
    end
    alu_valid = 0; mem_valid = 0;
    chk("t4_send_timeout", (guard < 100), 1);
    chk("t4_ready_dropped", seen_drop, 1);
    drain("t4");
    memv.delete();
    foreach (wlog[i]) if (wlog[i][35:32] == 4'd9) memv.push_back(wlog[i][31:0]);
    chk("t4_mem_count", memv.size(), 8);
    if (memv.size() == 8)
      for (int i = 0; i < 8; i++) chk("t4_mem_order", memv[i], i + 1);

    // 6. reset mid-operation
    alu_valid = 1; alu_rd = 4;
    for (int i = 1; i <= 3; i++) begin
      alu_data = 32'hA0 + i; cyc();
    end
    alu_valid = 0;
    chk("t6_pending", busy_mask[4], 1);
    #1 rst = 1'b0;
    #1;
    chk("t6_async_write", wb_write, 0);
    chk("t6_async_rd", wb_rd, 0);
    chk("t6_async_data", wb_data, 0);
    chk("t6_async_busy", busy_mask, 0);
    chk("t6_async_ready", {alu_ready, mem_ready}, 0);
    cyc();
    rst = 1'b1;
    wlog.delete();
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t6_no_write", wb_write, 0);
    end
    chk("t6_log_empty", wlog.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Initiator side of the register-file write port.
- Collects results from two producers, the ALU and the memory/load unit, over valid/ready handshakes.
- Buffers each producer's results in its own FIFO and arbitrates round-robin between them.
- Drives one registered write per cycle into the register file's rd/write/writeData inputs, and exports a pending-write mask for hazard checking.

Parameters:
- DEPTH, 4, entries per source FIFO; must be a power of 2 and at least 2.
- DATA_W, 32, write data width.
- ADDR_W, 4, register index width (16 registers).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low (0 = in reset).
- alu_valid  in  1  ALU result valid.
- alu_ready  out  1  ALU FIFO can accept an entry.
- alu_rd  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- mem_valid  in  1  load result valid.
- mem_ready  out  1  mem FIFO can accept an entry.
- mem_rd  in  ADDR_W  load destination register.
- mem_data  in  DATA_W  load result.
- wb_write  out  1  register-file write enable.
- wb_rd  out  ADDR_W  register-file write index.
- wb_data  out  DATA_W  register-file write data.
- busy_mask  out  16  bit r set while any write to Rr is queued or on the wb_* outputs.

Behaviour:
- Reset (rst=0, asynchronous):
  - Clears both FIFOs (pointers and counts).
  - wb_write=0, wb_rd=0, wb_data=0, busy_mask=0.
  - alu_ready=0 and mem_ready=0 while rst=0.
  - last_grant resets to MEM, so the ALU wins the first tie.
- Reset asserted mid-operation discards all queued entries. No wb_write occurs for them after release.
- Ready timing:
  - xx_ready = rst && !fifo_full, a function of registered state only.
  - xx_ready does not depend on a same-cycle pop. A full FIFO stays not-ready for the cycle even if it is popped.
- Push: at the edge where xx_valid && xx_ready, {rd, data} is written at the tail.
  - Valid without ready is ignored; the producer must hold.
- Arbiter, evaluated each cycle from FIFO state before the edge:
  - Both FIFOs empty: wb_write<=0 at the edge; wb_rd/wb_data hold their previous values.
  - Exactly one FIFO non-empty: that FIFO is granted.
  - Both non-empty: the source not equal to last_grant is granted.
  - On a grant: pop the head; wb_write<=1, wb_rd<=head.rd, wb_data<=head.data; last_grant<=granted source.
- Throughput: at most one write per cycle. The wb_* outputs are registered.
  - An entry pushed at edge k with no contention is popped at edge k+1.
  - wb_write is high for the cycle following edge k+1; the register file commits at edge k+2.
- Ordering:
  - Order within a source is strictly FIFO.
  - No ordering is guaranteed between sources. Producers must not issue conflicting rd to both sources concurrently.
- Simultaneous push and pop on the same FIFO in one cycle is legal; the count is unchanged.
- Writes to R0 are allowed and are forwarded like any other index.
- busy_mask (combinational over valid FIFO entries plus the wb_* register):
  - OR of one-hot(rd) over all occupied entries of both FIFOs.
  - Also includes one-hot(wb_rd) when wb_write=1.
- Pointers wrap modulo DEPTH. Count ranges 0..DEPTH; full means count==DEPTH.

Test Plan:
1. Reset check: hold rst=0 with random inputs.
   -> wb_write=0, wb_rd=0, wb_data=0, busy_mask=0, both ready=0.
   -> After release, both ready=1 on the next cycle.
2. Single write: ALU pushes rd=5, data=0xDEADBEEF at edge k.
   -> wb_write=1 with wb_rd=5, wb_data=0xDEADBEEF for exactly the one cycle after edge k+1.
   -> busy_mask[5]=1 from edge k until wb_write falls.
3. Contention: both sources push every cycle for 4 cycles (ALU rd=1, data 0x10..0x13; mem rd=2, data 0x20..0x23).
   -> wb sequence is 0x10, 0x20, 0x11, 0x21, 0x12, 0x22, 0x13, 0x23, alternating and starting with ALU.
4. Backpressure: mem pushes 8 entries (data 1..8) while the ALU pushes every cycle.
   -> mem_ready drops to 0 when 4 entries are held.
   -> All 8 mem values appear on wb in order 1..8, with none lost or duplicated.
5. Single source: mem alone pushes rd=3, data 1, 2, 3 back-to-back.
   -> wb_write is high for 3 consecutive cycles with R3 data 1, 2, 3.
   -> busy_mask[3] clears the cycle after the last write.
6. Reset mid-operation: queue 3 ALU entries, then assert rst=0 for 1 cycle.
   -> Outputs clear immediately (asynchronously).
   -> After release, no wb_write occurs until new pushes.
